glitch_pulse_sequencer: RTL and testbench
=========================================

Name: glitch_pulse_sequencer

Overview:
- Timing engine downstream of the glitcher AXI4-Lite register slave.
- Consumes the latched register fields: control, delay, width, gap and count.
- Waits for a qualified edge on an external trigger, then emits a burst of precisely timed glitch pulses on glitch_out.
- Reports busy/done/progress status back to the register slave for software readback.

Parameters:
- CNT_WIDTH, 32, width of the delay, width and gap counters (matches the 32-bit register data width).
- PCNT_WIDTH, 8, width of the pulse-count field and progress counter.
- SYNC_STAGES, 2, flip-flop synchroniser depth on trig_in (minimum 2).

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  asynchronous, active-high reset.
- cfg_arm  in  1  single-cycle arm strobe (ctrl bit0 write).
- cfg_abort  in  1  single-cycle abort strobe (ctrl bit1 write).
- cfg_edge  in  1  trigger edge select: 0 = rising, 1 = falling.
- cfg_delay  in  CNT_WIDTH  cycles from qualified trigger to first pulse.
- cfg_width  in  CNT_WIDTH  pulse high time in cycles.
- cfg_gap  in  CNT_WIDTH  low time between pulses in cycles.
- cfg_count  in  PCNT_WIDTH  number of pulses in the burst.
- trig_in  in  1  asynchronous external trigger.
- glitch_out  out  1  registered glitch pulse output.
- armed  out  1  high in ARMED state.
- busy  out  1  high in DELAY, PULSE or GAP.
- done  out  1  sticky burst-complete flag.
- pulses_done  out  PCNT_WIDTH  pulses completed in the current or last burst.

Behaviour:
- Reset: all flops clear asynchronously on ARESET high. State = IDLE; glitch_out, armed, busy, done = 0; pulses_done = 0; synchroniser cleared.
- Every output is registered.
- Trigger path:
  - trig_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - trig_q is a one-cycle pulse on the selected edge; cfg_edge is sampled from the latched copy.
  - trig_q is ignored in every state except ARMED.
- Config latching: on an accepted cfg_arm, cfg_edge, cfg_delay, cfg_width, cfg_gap and cfg_count are copied into internal shadow registers. Register writes during a burst have no effect until the next arm.
- Zero handling: a latched width of 0, gap of 0 or count of 0 is each treated as 1.
- FSM states: IDLE, ARMED, DELAY, PULSE, GAP, DONE.
  - IDLE / DONE, cfg_arm -> ARMED. Latch config; clear done and pulses_done.
  - ARMED, trig_q -> DELAY. Load counter with cfg_delay.
  - DELAY: counter decrements each cycle. When it reaches 0 -> PULSE; glitch_out goes high on that same clock edge.
  - Latency: glitch_out rises exactly delay+1 cycles after the cycle in which trig_q is high. With delay = 0 it rises on the next cycle.
  - PULSE: glitch_out stays high for exactly width cycles, then pulses_done increments.
    - If pulses_done equals count -> DONE.
    - Otherwise -> GAP.
  - GAP: glitch_out is low for exactly gap cycles, then -> PULSE.
  - DONE: done = 1 (sticky); glitch_out = 0. Stays in DONE until cfg_arm.
- cfg_arm in ARMED, DELAY, PULSE or GAP is ignored.
- cfg_abort in any state -> IDLE on the next edge:
  - glitch_out = 0 the following cycle;
  - done is not set;
  - pulses_done holds its value.
- Simultaneous cfg_abort and cfg_arm: abort wins; the block ends in IDLE.
- Simultaneous trig_q and cfg_abort in ARMED: abort wins.
- Counters are CNT_WIDTH bits. A latched delay of 2^CNT_WIDTH-1 must count fully with no wrap.
- pulses_done saturates at count and never wraps.
- ARESET asserted mid-burst: glitch_out drops asynchronously, with no partial pulse after release. After release the block stays in IDLE until armed.

Test Plan:
- Reset check: ARESET pulse mid-PULSE -> glitch_out, busy, done, pulses_done all 0 immediately; state IDLE; trig_in edges after release ignored.
- Single pulse: delay=10, width=5, count=1, edge=rising, arm, then rising trig_in -> glitch_out high 11 cycles after trig_q, high for exactly 5 cycles; done=1; pulses_done=1.
- Burst: delay=0, width=3, gap=4, count=3 -> pattern 3H/4L/3H/4L/3H starting 1 cycle after trig_q; pulses_done steps 1, 2, 3; then DONE.
- Edge select and zero values: edge=falling, width=0, gap=0, count=0; rising trig_in ignored, falling edge fires -> one pulse of 1 cycle.
- Abort: count=5, width=2, gap=2; abort after the 2nd pulse -> glitch_out 0 next cycle; busy=0; done=0; pulses_done=2. Arm and abort in the same cycle -> stays IDLE.
- Shadowing: arm with width=8, rewrite cfg_width=1 during DELAY -> pulse still 8 cycles. cfg_arm during GAP ignored.

Source files
------------

// File: rtl/glitch_pulse_sequencer.sv
// Glitch pulse sequencer: waits for a qualified trigger edge, then emits a
// burst of pulses with programmable delay, width, gap and count.
module glitch_pulse_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int PCNT_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic                  cfg_edge,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_gap,
  input  logic [PCNT_WIDTH-1:0] cfg_count,
  input  logic                  trig_in,
  output logic                  glitch_out,
  output logic                  armed,
  output logic                  busy,
  output logic                  done,
  output logic [PCNT_WIDTH-1:0] pulses_done
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [PCNT_WIDTH-1:0] PCNT_ONE = 1;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  trig_sync;
  logic                    trig_prev;
  logic                    trig_now;
  logic                    trig_q;
  logic                    edge_lat;
  logic [CNT_WIDTH-1:0]    delay_lat;
  logic [CNT_WIDTH-1:0]    width_lat;
  logic [CNT_WIDTH-1:0]    gap_lat;
  logic [PCNT_WIDTH-1:0]   count_lat;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [PCNT_WIDTH-1:0]   pulses_next;

  // A zero length or count is treated as one so a burst always makes progress.
  function automatic logic [CNT_WIDTH-1:0] nz_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  function automatic logic [PCNT_WIDTH-1:0] nz_pcnt(input logic [PCNT_WIDTH-1:0] v);
    return (v == '0) ? PCNT_ONE : v;
  endfunction

  // Metastability synchroniser followed by one edge-detect flop.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      trig_sync <= '0;
      trig_prev <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig_in};
      trig_prev <= trig_sync[SYNC_STAGES-1];
    end
  end

  assign trig_now = trig_sync[SYNC_STAGES-1];
  assign trig_q   = edge_lat ? (trig_prev & ~trig_now) : (trig_now & ~trig_prev);

  // Progress counter saturates at the latched count.
  assign pulses_next = (pulses_done < count_lat) ? pulses_done + PCNT_ONE : pulses_done;

  // Sequencer FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      glitch_out  <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_done <= '0;
      cnt         <= '0;
      edge_lat    <= 1'b0;
      delay_lat   <= '0;
      width_lat   <= CNT_ONE;
      gap_lat     <= CNT_ONE;
      count_lat   <= PCNT_ONE;
    end else if (cfg_abort) begin
      state      <= IDLE;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cfg_arm) begin
            state       <= ARMED;
            armed       <= 1'b1;
            done        <= 1'b0;
            pulses_done <= '0;
            edge_lat    <= cfg_edge;
            delay_lat   <= cfg_delay;
            width_lat   <= nz_cnt(cfg_width);
            gap_lat     <= nz_cnt(cfg_gap);
            count_lat   <= nz_pcnt(cfg_count);
          end
        end
        ARMED: begin
          if (trig_q) begin
            armed <= 1'b0;
            busy  <= 1'b1;
            // The delay phase lasts exactly delay cycles, so zero skips it.
            if (delay_lat == '0) begin
              state      <= PULSE;
              glitch_out <= 1'b1;
              cnt        <= width_lat - CNT_ONE;
            end else begin
              state <= DELAY;
              cnt   <= delay_lat - CNT_ONE;
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state      <= PULSE;
            glitch_out <= 1'b1;
            cnt        <= width_lat - CNT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            glitch_out  <= 1'b0;
            pulses_done <= pulses_next;
            if (pulses_next >= count_lat) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GAP;
              cnt   <= gap_lat - CNT_ONE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state      <= PULSE;
            glitch_out <= 1'b1;
            cnt        <= width_lat - CNT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state      <= IDLE;
          glitch_out <= 1'b0;
          armed      <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_pulse_sequencer.sv
// Directed bench for glitch_pulse_sequencer: table of burst configurations
// plus hand-written sequences for abort, shadowing, edge select and reset.
module tb_glitch_pulse_sequencer;

  localparam int BOUND = 400;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_arm, cfg_abort, cfg_edge;
  logic [31:0] cfg_delay, cfg_width, cfg_gap;
  logic [7:0]  cfg_count;
  logic        trig_in;
  logic        glitch_out, armed, busy, done;
  logic [7:0]  pulses_done;

  int checks   = 0;
  int failures = 0;

  glitch_pulse_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_edge(cfg_edge), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_gap(cfg_gap), .cfg_count(cfg_count), .trig_in(trig_in),
    .glitch_out(glitch_out), .armed(armed), .busy(busy), .done(done),
    .pulses_done(pulses_done)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        edge_sel;
    int unsigned delay;
    int unsigned width;
    int unsigned gap;
    int unsigned count;
    int          exp_lat;   // posedges from trig_in change to first high sample
    int          exp_w;
    int          exp_g;
    int          exp_n;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic arm(input logic e, input int unsigned d, input int unsigned w,
                     input int unsigned g, input int unsigned c);
    logic [31:0] cv;
    cv = c;
    @(negedge ACLK);
    cfg_edge  = e;
    cfg_delay = d;
    cfg_width = w;
    cfg_gap   = g;
    cfg_count = cv[7:0];
    cfg_arm   = 1'b1;
    @(negedge ACLK);
    cfg_arm = 1'b0;
  endtask

  task automatic prep(input logic idle_lvl);
    @(negedge ACLK);
    trig_in = idle_lvl;
    repeat (4) tick();
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    for (int i = 0; i < BOUND; i++) begin
      tick();
      k++;
      if (glitch_out === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL rise_timeout: got no rise within %0d cycles, required a rise", BOUND);
    k = -1;
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 1;
    for (int i = 0; i < BOUND; i++) begin
      tick();
      if (glitch_out !== lvl) return;
      len++;
    end
    checks++;
    failures++;
    $display("FAIL run_timeout: level %0d held over %0d cycles, required a change", lvl, BOUND);
  endtask

  initial begin
    int k, h, l;
    logic seen;

    ARESET = 1'b1; cfg_arm = 0; cfg_abort = 0; cfg_edge = 0;
    cfg_delay = 0; cfg_width = 0; cfg_gap = 0; cfg_count = 0; trig_in = 0;

    vecs[0] = '{1'b0, 10, 5, 0, 1, 13, 5, 1, 1};
    vecs[1] = '{1'b0,  0, 3, 4, 3,  3, 3, 4, 3};
    vecs[2] = '{1'b1,  2, 0, 0, 0,  5, 1, 1, 1};
    vecs[3] = '{1'b0,  1, 2, 1, 4,  4, 2, 1, 4};
    vecs[4] = '{1'b1,  0, 1, 0, 2,  3, 1, 1, 2};

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_glitch", glitch_out, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulses", pulses_done, 0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Table-driven bursts
    for (int v = 0; v < 5; v++) begin
      prep(vecs[v].edge_sel);
      arm(vecs[v].edge_sel, vecs[v].delay, vecs[v].width, vecs[v].gap, vecs[v].count);
      check($sformatf("v%0d_armed", v), armed, 1);
      trig_in = ~vecs[v].edge_sel;
      wait_rise(k);
      check($sformatf("v%0d_latency", v), k, vecs[v].exp_lat);
      check($sformatf("v%0d_busy", v), busy, 1);
      for (int p = 0; p < vecs[v].exp_n; p++) begin
        run_len(1'b1, h);
        check($sformatf("v%0d_width%0d", v, p), h, vecs[v].exp_w);
        check($sformatf("v%0d_pulses%0d", v, p), pulses_done, p + 1);
        if (p < vecs[v].exp_n - 1) begin
          run_len(1'b0, l);
          check($sformatf("v%0d_gap%0d", v, p), l, vecs[v].exp_g);
        end
      end
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      seen = 1'b0;
      repeat (4) begin
        tick();
        if (glitch_out) seen = 1'b1;
      end
      check($sformatf("v%0d_quiet", v), seen, 0);
    end

    // Falling edge select with zero width/gap/count: rising edge ignored
    prep(1'b0);
    arm(1'b1, 0, 0, 0, 0);
    trig_in = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (glitch_out) seen = 1'b1;
    end
    check("edge_rising_ignored", seen, 0);
    check("edge_still_armed", armed, 1);
    @(negedge ACLK);
    trig_in = 1'b0;
    wait_rise(k);
    check("edge_fall_latency", k, 3);
    run_len(1'b1, h);
    check("edge_width", h, 1);
    check("edge_pulses", pulses_done, 1);
    check("edge_done", done, 1);

    // Shadowing: width rewrite in DELAY and arm in GAP have no effect
    prep(1'b0);
    arm(1'b0, 10, 8, 3, 2);
    trig_in = 1'b1;
    repeat (5) tick();
    @(negedge ACLK);
    cfg_width = 1;
    wait_rise(k);
    check("shadow_latency", k, 8);
    run_len(1'b1, h);
    check("shadow_width1", h, 8);
    @(negedge ACLK);
    cfg_arm = 1'b1;
    cfg_delay = 0;
    tick();
    check("shadow_gap_arm_glitch", glitch_out, 0);
    check("shadow_gap_arm_armed", armed, 0);
    @(negedge ACLK);
    cfg_arm = 1'b0;
    run_len(1'b0, l);
    check("shadow_gap_rest", l, 2);
    run_len(1'b1, h);
    check("shadow_width2", h, 8);
    check("shadow_done", done, 1);
    check("shadow_pulses", pulses_done, 2);

    // Abort while the pulse is high
    prep(1'b0);
    arm(1'b0, 3, 6, 2, 2);
    trig_in = 1'b1;
    wait_rise(k);
    check("abortp_latency", k, 6);
    tick();
    @(negedge ACLK);
    cfg_abort = 1'b1;
    tick();
    check("abortp_glitch", glitch_out, 0);
    check("abortp_busy", busy, 0);
    check("abortp_done", done, 0);
    check("abortp_pulses", pulses_done, 0);
    @(negedge ACLK);
    cfg_abort = 1'b0;

    // Abort after the second pulse of five
    prep(1'b0);
    arm(1'b0, 0, 2, 2, 5);
    trig_in = 1'b1;
    wait_rise(k);
    run_len(1'b1, h);
    run_len(1'b0, l);
    run_len(1'b1, h);
    check("abort2_pre_pulses", pulses_done, 2);
    @(negedge ACLK);
    cfg_abort = 1'b1;
    tick();
    check("abort2_glitch", glitch_out, 0);
    check("abort2_busy", busy, 0);
    check("abort2_done", done, 0);
    check("abort2_pulses", pulses_done, 2);
    @(negedge ACLK);
    cfg_abort = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (glitch_out) seen = 1'b1;
    end
    check("abort2_no_more_pulses", seen, 0);

    // Arm and abort together: abort wins, block stays idle
    @(negedge ACLK);
    cfg_arm = 1'b1;
    cfg_abort = 1'b1;
    tick();
    check("armabort_armed", armed, 0);
    check("armabort_pulses", pulses_done, 2);
    @(negedge ACLK);
    cfg_arm = 1'b0;
    cfg_abort = 1'b0;
    trig_in = 1'b0;
    repeat (4) tick();
    @(negedge ACLK);
    trig_in = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (glitch_out || busy) seen = 1'b1;
    end
    check("armabort_trig_ignored", seen, 0);

    // Asynchronous reset in the middle of the second pulse
    prep(1'b0);
    arm(1'b0, 0, 3, 4, 3);
    trig_in = 1'b1;
    wait_rise(k);
    run_len(1'b1, h);
    run_len(1'b0, l);
    check("rstmid_pre_glitch", glitch_out, 1);
    check("rstmid_pre_pulses", pulses_done, 1);
    #2;
    ARESET = 1'b1;
    #1;
    check("rstmid_glitch", glitch_out, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_pulses", pulses_done, 0);
    check("rstmid_armed", armed, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      trig_in = ~trig_in;
      repeat (4) begin
        tick();
        if (glitch_out || busy || armed) seen = 1'b1;
      end
    end
    check("rstmid_stays_idle", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
